// File: rtl/adder_bist.sv
// Exhaustive built-in self-test for a combinational adder.
// Walks every {a, b, cin} combination. Each vector is held for SETTLE cycles
// and then checked for one cycle against a full-width reference sum.
// The block records the number of mismatches and the first failing vector.
`timescale 1ns/1ps

module adder_bist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_s,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int unsigned VW = 2 * WIDTH + 1;

    // The wait counter is 4 bits wide because SETTLE is at most 15.
    localparam logic [3:0]    WaitLoad = 4'(SETTLE - 1);
    localparam logic [VW-1:0] VecLast  = {VW{1'b1}};
    localparam logic [15:0]   ErrMax   = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCheck  = 2'd2,
        StDone   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [VW-1:0] vec_q, vec_d;
    logic [3:0]    wait_q, wait_d;
    logic [15:0]   err_q, err_d;
    logic [VW-1:0] ff_q, ff_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    // Decoded FSM events shared by the next-state and datapath logic.
    logic          accept;
    logic          settle_end;
    logic          last_vec;
    logic          mismatch;
    logic [WIDTH:0] ref_sum;
    logic [WIDTH:0] got_sum;

    // Start is honoured only outside a run; while busy it is ignored.
    assign accept     = start && ((state_q == StIdle) || (state_q == StDone));
    assign settle_end = (state_q == StSettle) && (wait_q == 4'd0);
    assign last_vec   = (vec_q == VecLast);

    // Reference sum at WIDTH+1 bits so that the carry-out is checked as well.
    always_comb begin
        ref_sum = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
        got_sum = {dut_cout, dut_s};
        mismatch = (got_sum != ref_sum);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (settle_end) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = last_vec ? StDone : StSettle;
            end
            StDone: begin
                if (accept) begin
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: the vector is presented only while a run is in progress.
    always_comb begin
        dut_a   = '0;
        dut_b   = '0;
        dut_cin = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StSettle, StCheck: begin
                {dut_a, dut_b, dut_cin} = vec_q;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath next-state logic: vector walk, settle timer and result capture.
    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        err_d  = err_q;
        ff_d   = ff_q;
        done_d = done_q;
        pass_d = pass_q;

        if (accept) begin
            vec_d  = '0;
            wait_d = WaitLoad;
            err_d  = '0;
            ff_d   = '0;
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if ((state_q == StSettle) && !settle_end) begin
            wait_d = wait_q - 4'd1;
        end else if (state_q == StCheck) begin
            if (mismatch) begin
                // The first failure is captured while the count is still zero.
                if (err_q == 16'd0) begin
                    ff_d = vec_q;
                end
                if (err_q != ErrMax) begin
                    err_d = err_q + 16'd1;
                end
            end
            if (last_vec) begin
                // The verdict includes the comparison made in this same cycle.
                done_d = 1'b1;
                pass_d = (err_d == 16'd0);
            end else begin
                vec_d  = vec_q + VW'(1);
                wait_d = WaitLoad;
            end
        end
    end

    // Datapath registers; reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            wait_q <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_adder_bist.sv
// Randomised self-checking bench for adder_bist.
// A WIDTH=1 instance tests a fault-injectable full adder. A WIDTH=4, SETTLE=1
// instance checks run latency. Expected results come from walking every
// vector through the attached adder's behaviour and comparing against true
// arithmetic.
`timescale 1ns/1ps

module tb_adder_bist;

    localparam int unsigned W1 = 1;
    localparam int unsigned S1 = 2;
    localparam int unsigned W4 = 4;
    localparam int unsigned S4 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic start4 = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=1 instance signals
    logic [W1-1:0] a, b, s;
    logic          cin, cout;
    logic          busy, done, pass;
    logic [15:0]   err;
    logic [2:0]    ff;

    // WIDTH=4 instance signals
    logic [W4-1:0] a4, b4, s4;
    logic          cin4, cout4;
    logic          busy4, done4, pass4;
    logic [15:0]   err4;
    logic [8:0]    ff4;

    // Fault selection for the adder under test:
    // 0 good, 1 cout stuck at 0, 2 sum inverted, 3 xor mask on one vector.
    int         mode = 0;
    logic [2:0] trig = 3'd0;
    logic [1:0] mask = 2'd1;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [1:0] adder_resp(input int m, input logic [2:0] t,
                                              input logic [1:0] mk, input logic x,
                                              input logic y, input logic c);
        logic [1:0] r;
        r = 2'(x) + 2'(y) + 2'(c);
        case (m)
            1: r[1] = 1'b0;
            2: r[0] = ~r[0];
            3: if ({x, y, c} == t) r = r ^ mk;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout, s} = adder_resp(mode, trig, mask, a[0], b[0], cin);
    always_comb {cout4, s4} = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};

    adder_bist #(.WIDTH(W1), .SETTLE(S1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_a      (a),
        .dut_b      (b),
        .dut_cin    (cin),
        .dut_s      (s),
        .dut_cout   (cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err),
        .first_fail (ff)
    );

    adder_bist #(.WIDTH(W4), .SETTLE(S4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .dut_a      (a4),
        .dut_b      (b4),
        .dut_cin    (cin4),
        .dut_s      (s4),
        .dut_cout   (cout4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .err_count  (err4),
        .first_fail (ff4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected run result: every vector in order, true sum vs. adder response.
    task automatic model_run(input int m, output int errs, output logic [2:0] ffe,
                             output logic pe);
        errs = 0;
        ffe  = 3'd0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            logic [1:0] good;
            vb   = 3'(v);
            good = 2'(vb[2]) + 2'(vb[1]) + 2'(vb[0]);
            if (adder_resp(m, trig, mask, vb[2], vb[1], vb[0]) != good) begin
                if (errs == 0) ffe = vb;
                errs++;
            end
        end
        pe = (errs == 0);
    endtask

    task automatic do_run(input int m, input bit repulse);
        int         errs;
        logic [2:0] ffe;
        logic       pe;
        int         cyc;
        int         probe;
        mode = m;
        model_run(m, errs, ffe, pe);
        probe = $urandom_range(0, 23);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("accept_done_low", done, 0);
        check_eq("accept_err_clear", err, 0);
        check_eq("accept_ff_clear", ff, 0);
        check_eq("accept_busy", busy, 1);

        cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc == probe) begin
                // Each vector occupies SETTLE+1 = 3 cycles.
                check_eq("operand_vector", {a, b, cin}, cyc / 3);
                check_eq("busy_mid", busy, 1);
            end
            if (repulse && cyc == 10) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_eq("run_latency", cyc, 24);
        check_eq("done_end", done, 1);
        check_eq("busy_end", busy, 0);
        check_eq("pass", pass, pe);
        check_eq("err_count", err, errs);
        check_eq("first_fail", ff, ffe);
        check_eq("idle_operands", {a, b, cin}, 0);

        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check_eq("hold_done", done, 1);
        check_eq("hold_err", err, errs);
    endtask

    initial begin
        int cyc;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ff", ff, 0);
        check_eq("rst_operands", {a, b, cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_wait", busy, 0);

        do_run(0, 1'b0);
        do_run(1, 1'b0);
        check_eq("stuck_cout_count", err, 4);
        check_eq("stuck_cout_first", ff, 3);
        do_run(2, 1'b0);
        check_eq("inv_sum_count", err, 8);
        do_run(1, 1'b1);
        do_run(1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            trig = 3'($urandom_range(0, 7));
            mask = 2'($urandom_range(1, 3));
            do_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a faulty run.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_err", err, 0);
        check_eq("abort_ff", ff, 0);
        check_eq("abort_operands", {a, b, cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_idle", {busy, done}, 0);
        do_run(0, 1'b0);

        // Wider instance: done after (1+1)*2^9 edges.
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("w4_latency", cyc, 1024);
        check_eq("w4_pass", pass4, 1);
        check_eq("w4_err", err4, 0);
        check_eq("w4_ff", ff4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
